// File: rtl/comb_sweep_checker_pkg.sv
// -----------------------------------------------------------------------------
// comb_sweep_checker_pkg
//
// Shared definitions for the combinational-element sweep checker:
//   - FSM state encodings (2-bit)
//   - golden truth table of the element o = ~((a&b)|(c^d)), bit i = o for
//     {a,b,c,d} = i
//   - number of input vectors swept
// -----------------------------------------------------------------------------
package comb_sweep_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } sweep_state_t;

    localparam logic [15:0] T11_EXPECTED = 16'h0999;
    localparam int          T11_NVEC     = 16;

endpackage

// File: rtl/comb_sweep_checker.sv
// -----------------------------------------------------------------------------
// comb_sweep_checker
//
// Synthesizable stimulus-and-capture stage for a 4-input combinational element.
// On an accepted start it drives all 16 {a,b,c,d} vectors in ascending order,
// holds each one for SETTLE_CYCLES cycles plus one sample cycle, captures the
// element output into a truth table and compares it bit by bit against
// EXPECTED.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   start          in   1   sweep request, only looked at in IDLE
//   abcd_out       out  4   vector to the element, {a,b,c,d}
//   o_in           in   1   element output (same clock domain, no synchronizer)
//   busy           out  1   high while a sweep is running
//   done           out  1   one-cycle pulse at sweep completion
//   table_out      out  16  captured truth table, bit i for vector i
//   fail           out  1   sticky, any captured bit differed from EXPECTED
//   mismatch_count out  5   number of mismatching vectors (0..16)
//   first_fail_idx out  4   lowest mismatching vector, 0 when fail=0
// -----------------------------------------------------------------------------
module comb_sweep_checker
    import comb_sweep_checker_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = T11_EXPECTED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  abcd_out,
    input  logic        o_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        fail,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail_idx
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("comb_sweep_checker: SETTLE_CYCLES must be >= 1");
    end

    // Counter wide enough to hold SETTLE_CYCLES, so the free-running increment
    // on the last DRIVE edge never wraps.
    localparam int             CW         = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]  SETTLE_END = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]     LAST_IDX   = 4'(T11_NVEC - 1);

    sweep_state_t  state;
    sweep_state_t  state_next;
    logic [3:0]    idx;
    logic [CW-1:0] settle_cnt;
    logic          sample_bad;

    assign sample_bad = (o_in != EXPECTED[idx]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the last vector leaves SAMPLE for DONE explicitly, so
    // idx never has to wrap.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_DRIVE;
            S_DRIVE:  if (settle_cnt == SETTLE_END) state_next = S_SAMPLE;
            S_SAMPLE: state_next = (idx == LAST_IDX) ? S_DONE : S_DRIVE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath: vector drive, settle timing, capture and comparison. abcd_out
    // only changes on edges that enter DRIVE, so the element input is stable
    // for the whole settle window and the sample cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= '0;
            settle_cnt     <= '0;
            abcd_out       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            table_out      <= '0;
            fail           <= 1'b0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        idx            <= '0;
                        abcd_out       <= '0;
                        settle_cnt     <= '0;
                        table_out      <= '0;
                        fail           <= 1'b0;
                        mismatch_count <= '0;
                        first_fail_idx <= '0;
                    end
                end
                S_DRIVE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                S_SAMPLE: begin
                    table_out[idx] <= o_in;
                    if (sample_bad) begin
                        mismatch_count <= mismatch_count + 5'd1;
                        fail           <= 1'b1;
                        // fail is still low on the first mismatch of a sweep
                        if (!fail) begin
                            first_fail_idx <= idx;
                        end
                    end
                    if (idx != LAST_IDX) begin
                        idx        <= idx + 4'd1;
                        abcd_out   <= idx + 4'd1;
                        settle_cnt <= '0;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comb_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_comb_sweep_checker
//
// Self-checking bench for comb_sweep_checker. The element o = ~((a&b)|(c^d))
// is modelled here, optionally corrupted by a random per-vector flip mask or
// tied high, and the expected table / mismatch statistics are derived from
// that element model by plain loops. A second instance with SETTLE_CYCLES=4
// checks the longer hold time.
// -----------------------------------------------------------------------------
module tb_comb_sweep_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  abcd_out;
    logic        o_in;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        fail;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail_idx;

    logic        start4;
    logic [3:0]  abcd_out4;
    logic        o_in4;
    logic        busy4;
    logic        done4;
    logic [15:0] table_out4;
    logic        fail4;
    logic [4:0]  mismatch_count4;
    logic [3:0]  first_fail_idx4;

    logic [15:0] flip_mask;
    logic        tie_high;
    int          errors;
    int          checks;

    comb_sweep_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abcd_out       (abcd_out),
        .o_in           (o_in),
        .busy           (busy),
        .done           (done),
        .table_out      (table_out),
        .fail           (fail),
        .mismatch_count (mismatch_count),
        .first_fail_idx (first_fail_idx)
    );

    comb_sweep_checker #(.SETTLE_CYCLES(4)) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start4),
        .abcd_out       (abcd_out4),
        .o_in           (o_in4),
        .busy           (busy4),
        .done           (done4),
        .table_out      (table_out4),
        .fail           (fail4),
        .mismatch_count (mismatch_count4),
        .first_fail_idx (first_fail_idx4)
    );

    // Behavioural element plus fault injection in front of the main DUT.
    assign o_in  = tie_high ? 1'b1
                 : (~((abcd_out[3] & abcd_out[2]) | (abcd_out[1] ^ abcd_out[0])) ^ flip_mask[abcd_out]);
    assign o_in4 = ~((abcd_out4[3] & abcd_out4[2]) | (abcd_out4[1] ^ abcd_out4[0]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] goldenTable();
        logic [15:0] t;
        logic [3:0]  v;
        for (int i = 0; i < 16; i++) begin
            v    = 4'(i);
            t[i] = ~((v[3] & v[2]) | (v[1] ^ v[0]));
        end
        return t;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    // Raises start so that it is sampled on the next edge (E0), then drops it.
    task automatic applyStimulus();
        start = 1'b1;
        waitEdge();
        start = 1'b0;
    endtask

    // One full sweep on the default instance, with the abcd sequence and
    // done/busy timing checked every cycle and results checked at done.
    task automatic runSweep(input logic [15:0] flip, input logic tie, input logic repulse);
        logic [15:0] golden;
        logic [15:0] exp_tbl;
        int          exp_cnt;
        int          exp_first;
        int          exp_abcd;
        golden    = goldenTable();
        flip_mask = flip;
        tie_high  = tie;
        exp_tbl   = tie ? 16'hFFFF : (golden ^ flip);
        exp_cnt   = 0;
        exp_first = -1;
        for (int i = 0; i < 16; i++) begin
            if (exp_tbl[i] != golden[i]) begin
                exp_cnt++;
                if (exp_first < 0) exp_first = i;
            end
        end
        if (exp_first < 0) exp_first = 0;

        applyStimulus();
        checkOutput("accept_busy", 32'(busy), 32'd1);
        checkOutput("accept_table_clear", 32'(table_out), 32'd0);
        checkOutput("accept_abcd", 32'(abcd_out), 32'd0);
        for (int k = 1; k <= 50; k++) begin
            waitEdge();
            exp_abcd = (k / 3 > 15) ? 15 : k / 3;
            checkOutput("abcd_seq", 32'(abcd_out), 32'(exp_abcd));
            checkOutput("busy_t", 32'(busy), 32'(k < 48));
            checkOutput("done_t", 32'(done), 32'(k == 48));
            if (k == 48) begin
                checkOutput("table", 32'(table_out), 32'(exp_tbl));
                checkOutput("fail", 32'(fail), 32'(exp_cnt != 0));
                checkOutput("mismatch_count", 32'(mismatch_count), 32'(exp_cnt));
                checkOutput("first_fail_idx", 32'(first_fail_idx), 32'(exp_first));
            end
            if (k == 50) begin
                checkOutput("hold_table", 32'(table_out), 32'(exp_tbl));
            end
            start = repulse && (k == 9 || k == 29);
        end
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] golden;
        int          exp_abcd;
        errors    = 0;
        checks    = 0;
        start     = 1'b0;
        start4    = 1'b0;
        flip_mask = 16'h0000;
        tie_high  = 1'b0;
        golden    = goldenTable();

        $display("[TB] reset");
        rst_n = 1'b0;
        #1;
        checkOutput("rst_abcd", 32'(abcd_out), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_table", 32'(table_out), 32'd0);
        checkOutput("rst_fail", 32'(fail), 32'd0);
        checkOutput("rst_count", 32'(mismatch_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitEdge();

        $display("[TB] clean sweep");
        runSweep(16'h0000, 1'b0, 1'b0);
        $display("[TB] o_in tied high");
        runSweep(16'h0000, 1'b1, 1'b0);
        $display("[TB] start re-pulsed mid sweep");
        runSweep(16'h0000, 1'b0, 1'b1);
        $display("[TB] random fault masks");
        for (int r = 0; r < 4; r++) begin
            runSweep(16'($urandom), 1'b0, 1'b0);
        end
        runSweep(16'h8000, 1'b0, 1'b0);

        $display("[TB] SETTLE_CYCLES=4 instance");
        start4 = 1'b1;
        waitEdge();
        start4 = 1'b0;
        for (int k = 1; k <= 82; k++) begin
            waitEdge();
            exp_abcd = (k / 5 > 15) ? 15 : k / 5;
            checkOutput("s4_abcd_seq", 32'(abcd_out4), 32'(exp_abcd));
            checkOutput("s4_done_t", 32'(done4), 32'(k == 80));
            if (k == 80) begin
                checkOutput("s4_table", 32'(table_out4), 32'(golden));
                checkOutput("s4_fail", 32'(fail4), 32'd0);
            end
        end

        $display("[TB] async reset mid sweep");
        flip_mask = 16'h0001;
        tie_high  = 1'b0;
        applyStimulus();
        repeat (20) waitEdge();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_abcd", 32'(abcd_out), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_table", 32'(table_out), 32'd0);
        checkOutput("mid_rst_fail", 32'(fail), 32'd0);
        checkOutput("mid_rst_count", 32'(mismatch_count), 32'd0);
        checkOutput("mid_rst_first", 32'(first_fail_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            waitEdge();
            checkOutput("post_rst_abcd", 32'(abcd_out), 32'd0);
            checkOutput("post_rst_done", 32'(done), 32'd0);
        end

        $display("[TB] start held high");
        flip_mask = 16'h0000;
        applyStimulus();
        start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            waitEdge();
            checkOutput("held_done_t", 32'(done), 32'(k == 48 || k == 98));
            if (k == 50) begin
                checkOutput("held_table_clear", 32'(table_out), 32'd0);
                checkOutput("held_busy", 32'(busy), 32'd1);
            end
            if (k == 60) begin
                checkOutput("held_table_partial", 32'(table_out), 32'(golden & 16'h0007));
            end
            if (k == 98) begin
                checkOutput("held_table_final", 32'(table_out), 32'(golden));
                checkOutput("held_fail", 32'(fail), 32'd0);
                start = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
